// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and helpers for the unified memory arbiter.
package unified_mem_arbiter_pkg;

  // Arbiter operating phase.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } arb_state_e;

  // One-hot record of which requester owns the memory this cycle.
  typedef enum logic [2:0] {
    GNT_NONE  = 3'b000,
    GNT_EXT   = 3'b001,
    GNT_DATA  = 3'b010,
    GNT_FETCH = 3'b100
  } gnt_e;

  // Read-return channels: loads and instruction fetches.
  localparam int NUM_RD_PORTS = 2;
  localparam int RD_DATA      = 0;
  localparam int RD_FETCH     = 1;

  // Bits needed to hold a count from 0 up to max_count inclusive.
  function automatic int streak_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

  // Fixed priority loader > data > fetch. Data yields to a waiting fetch
  // once its streak has run out, but only while fetch is being served at all.
  function automatic gnt_e pick_grant(
    input logic       ext_req,
    input logic       d_req,
    input logic       f_req,
    input arb_state_e state,
    input logic       streak_full
  );
    logic data_ok;
    logic fetch_ok;
    data_ok  = (state != ST_BOOT) && !((state == ST_RUN) && f_req && streak_full);
    fetch_ok = (state == ST_RUN);
    if (ext_req)
      return GNT_EXT;
    else if (d_req && data_ok)
      return GNT_DATA;
    else if (f_req && fetch_ok)
      return GNT_FETCH;
    return GNT_NONE;
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_streak_counter.sv
// Saturating counter of back-to-back data grants taken while fetch waits.
module unified_mem_arbiter_streak_counter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int MAX_COUNT = 4
) (
  input  logic clk,
  input  logic srst,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam int CW = streak_width(MAX_COUNT);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_COUNT);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  // Clear wins over increment; increment stops at the limit.
  always_comb begin
    count_next = count_reg;
    if (clr)
      count_next = '0;
    else if (inc && (count_reg != LIMIT))
      count_next = count_reg + CW'(1);
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (srst)
      count_reg <= '0;
    else
      count_reg <= count_next;
  end

  assign at_limit = (count_reg == LIMIT);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port memory shared by boot loader, data access and instruction fetch.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int WORD_SIZE       = 32,
  parameter int ADDR_WIDTH      = 10,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_ext_req,
  input  logic [WORD_SIZE-1:0]  i_ext_addr,
  input  logic [WORD_SIZE-1:0]  i_ext_data,
  input  logic                  i_boot_done,
  input  logic                  i_halt,
  input  logic                  i_d_req,
  input  logic                  i_d_we,
  input  logic [WORD_SIZE-1:0]  i_d_addr,
  input  logic [WORD_SIZE-1:0]  i_d_wdata,
  output logic                  o_d_gnt,
  output logic                  o_d_rvalid,
  output logic [WORD_SIZE-1:0]  o_d_rdata,
  input  logic                  i_f_req,
  input  logic [WORD_SIZE-1:0]  i_f_addr,
  output logic                  o_f_gnt,
  output logic                  o_f_rvalid,
  output logic [WORD_SIZE-1:0]  o_f_rdata,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [WORD_SIZE-1:0]  o_mem_data,
  output logic                  o_mem_we,
  input  logic [WORD_SIZE-1:0]  i_mem_q
);

  arb_state_e             state_reg;
  arb_state_e             state_next;
  gnt_e                   gnt;
  logic [WORD_SIZE-1:0]   sel_addr;
  logic [WORD_SIZE-1:0]   mem_data;
  logic                   mem_we;
  logic                   streak_full;
  logic                   streak_clr;
  logic                   streak_inc;
  logic [NUM_RD_PORTS-1:0] rd_fire;
  logic [NUM_RD_PORTS-1:0] rd_valid;
  logic [WORD_SIZE-1:0]   rd_data [NUM_RD_PORTS];
  logic                   unused_addr_bits;

  // Phase register; HALT is only left through reset.
  always_ff @(posedge i_CLK) begin
    if (i_RST)
      state_reg <= ST_BOOT;
    else
      state_reg <= state_next;
  end

  // Next phase, grant decision and memory port steering.
  always_comb begin
    state_next = state_reg;
    gnt        = pick_grant(i_ext_req, i_d_req, i_f_req, state_reg, streak_full);
    sel_addr   = '0;
    mem_data   = '0;
    mem_we     = 1'b0;

    case (state_reg)
      ST_BOOT: if (i_boot_done) state_next = ST_RUN;
      ST_RUN:  if (i_halt) state_next = ST_HALT;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_BOOT;
    endcase

    case (gnt)
      GNT_EXT: begin
        sel_addr = i_ext_addr;
        mem_data = i_ext_data;
        mem_we   = 1'b1;
      end
      GNT_DATA: begin
        sel_addr = i_d_addr;
        mem_data = i_d_wdata;
        mem_we   = i_d_we;
      end
      GNT_FETCH: begin
        sel_addr = i_f_addr;
      end
      default: begin
        sel_addr = '0;
      end
    endcase
  end

  // A fetch grant or an absent fetch request ends the streak; loader cycles leave it alone.
  assign streak_clr = !i_f_req || (gnt == GNT_FETCH);
  assign streak_inc = (gnt == GNT_DATA) && i_f_req;

  unified_mem_arbiter_streak_counter #(
    .MAX_COUNT(MAX_DATA_STREAK)
  ) u_streak (
    .clk     (i_CLK),
    .srst    (i_RST),
    .clr     (streak_clr),
    .inc     (streak_inc),
    .at_limit(streak_full)
  );

  // Memory interface: word address from the byte address; no write while in reset.
  assign o_mem_addr       = sel_addr[ADDR_WIDTH+1:2];
  assign o_mem_data       = mem_data;
  assign o_mem_we         = mem_we & ~i_RST;
  assign unused_addr_bits = ^{sel_addr[WORD_SIZE-1:ADDR_WIDTH+2], sel_addr[1:0]};

  assign o_d_gnt = (gnt == GNT_DATA);
  assign o_f_gnt = (gnt == GNT_FETCH);

  // Which read channels capture memory data on the coming edge.
  assign rd_fire[RD_DATA]  = (gnt == GNT_DATA) && !i_d_we;
  assign rd_fire[RD_FETCH] = (gnt == GNT_FETCH);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd
      logic                 valid_reg;
      logic [WORD_SIZE-1:0] data_reg;

      // One-cycle valid pulse; data holds until the next read on this channel.
      always_ff @(posedge i_CLK) begin
        if (i_RST) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else begin
          valid_reg <= rd_fire[gi];
          if (rd_fire[gi])
            data_reg <= i_mem_q;
        end
      end

      assign rd_valid[gi] = valid_reg;
      assign rd_data[gi]  = data_reg;
    end
  endgenerate

  assign o_d_rvalid = rd_valid[RD_DATA];
  assign o_d_rdata  = rd_data[RD_DATA];
  assign o_f_rvalid = rd_valid[RD_FETCH];
  assign o_f_rdata  = rd_data[RD_FETCH];

endmodule
